// File: rtl/mux4_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mux4_burst_arbiter
//  Purpose  : Round-robin burst arbiter that drives the 32-bit 4:1 operand mux
//             select and a valid/ready handshake toward the consumer.
//  Revision : 1.0 - initial release
// ============================================================================
module mux4_burst_arbiter #(
    parameter int LEN_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [4*LEN_W-1:0] len,
    input  logic               out_ready,
    output logic [1:0]         select,
    output logic [3:0]         grant,
    output logic               out_valid,
    output logic               out_last,
    output logic [3:0]         word_ack,
    output logic               busy
);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_BURST = 1'b1;

    logic [0:0]       r_state;
    logic [1:0]       r_ptr;
    logic [1:0]       r_select;
    logic [3:0]       r_grant;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_blen;

    logic [0:0]       w_nxt_state;
    logic [1:0]       w_nxt_ptr;
    logic [1:0]       w_nxt_select;
    logic [3:0]       w_nxt_grant;
    logic [LEN_W-1:0] w_nxt_cnt;
    logic [LEN_W-1:0] w_nxt_blen;

    logic [LEN_W-1:0] w_len_arr [4];
    logic [1:0]       w_arb_ptr;
    logic [7:0]       w_req_dbl;
    logic [3:0]       w_req_rot;
    logic [1:0]       w_win_off;
    logic [1:0]       w_win_idx;
    logic [3:0]       w_win_onehot;
    logic [LEN_W-1:0] w_win_len;
    logic             w_any_req;
    logic             w_in_burst;
    logic             w_accept;
    logic             w_last;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_len_unpack
            assign w_len_arr[gi] = len[gi*LEN_W +: LEN_W];
        end
    endgenerate

    assign w_in_burst = (r_state == c_ST_BURST);
    assign w_last     = w_in_burst && (r_cnt == r_blen);
    assign w_accept   = w_in_burst && out_ready;
    assign w_any_req  = |req;

    // At a burst boundary the pointer has not been written yet, so the
    // scan starts from the position one past the current owner directly.
    always_comb begin
        w_arb_ptr = w_in_burst ? (r_select + 2'd1) : r_ptr;
        w_req_dbl = {req, req};
        w_req_rot = 4'(w_req_dbl >> w_arb_ptr);
        if (w_req_rot[0])      w_win_off = 2'd0;
        else if (w_req_rot[1]) w_win_off = 2'd1;
        else if (w_req_rot[2]) w_win_off = 2'd2;
        else                   w_win_off = 2'd3;
        w_win_idx    = w_arb_ptr + w_win_off;
        w_win_onehot = 4'b0001 << w_win_idx;
        w_win_len    = w_len_arr[w_win_idx];
    end

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_ptr    = r_ptr;
        w_nxt_select = r_select;
        w_nxt_grant  = r_grant;
        w_nxt_cnt    = r_cnt;
        w_nxt_blen   = r_blen;
        case (r_state)
            c_ST_IDLE: begin
                if (w_any_req) begin
                    w_nxt_state  = c_ST_BURST;
                    w_nxt_select = w_win_idx;
                    w_nxt_grant  = w_win_onehot;
                    w_nxt_blen   = w_win_len;
                    w_nxt_cnt    = '0;
                end
            end
            c_ST_BURST: begin
                if (w_accept) begin
                    if (w_last) begin
                        w_nxt_ptr = r_select + 2'd1;
                        if (w_any_req) begin
                            w_nxt_select = w_win_idx;
                            w_nxt_grant  = w_win_onehot;
                            w_nxt_blen   = w_win_len;
                            w_nxt_cnt    = '0;
                        end else begin
                            w_nxt_state = c_ST_IDLE;
                            w_nxt_grant = '0;
                        end
                    end else begin
                        w_nxt_cnt = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_nxt_state = c_ST_IDLE;
                w_nxt_grant = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_ptr    <= '0;
            r_select <= '0;
            r_grant  <= '0;
            r_cnt    <= '0;
            r_blen   <= '0;
        end else begin
            r_state  <= w_nxt_state;
            r_ptr    <= w_nxt_ptr;
            r_select <= w_nxt_select;
            r_grant  <= w_nxt_grant;
            r_cnt    <= w_nxt_cnt;
            r_blen   <= w_nxt_blen;
        end
    end

    assign select    = r_select;
    assign grant     = r_grant;
    assign out_valid = w_in_burst;
    assign busy      = w_in_burst;
    assign out_last  = w_last;
    assign word_ack  = w_accept ? r_grant : 4'b0000;

endmodule
`default_nettype wire

// File: tb/tb_mux4_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux4_burst_arbiter
//  Purpose  : Self-checking vector bench for mux4_burst_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux4_burst_arbiter;

    localparam int LEN_W = 4;

    logic               clk;
    logic               rst;
    logic [3:0]         req;
    logic [4*LEN_W-1:0] len;
    logic               out_ready;
    logic [1:0]         select;
    logic [3:0]         grant;
    logic               out_valid;
    logic               out_last;
    logic [3:0]         word_ack;
    logic               busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [15:0] len;
        logic        rdy;
        logic [3:0]  g;
        logic [1:0]  s;
        logic        sx;   // select not checked (idle after a burst)
        logic        v;
        logic        l;
        logic [3:0]  a;
    } vec_t;

    vec_t vt[$];

    mux4_burst_arbiter #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .len       (len),
        .out_ready (out_ready),
        .select    (select),
        .grant     (grant),
        .out_valid (out_valid),
        .out_last  (out_last),
        .word_ack  (word_ack),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [3:0] q, input logic [15:0] ln,
                       input logic rd, input logic [3:0] g, input logic [1:0] s,
                       input logic sx, input logic v, input logic l, input logic [3:0] a);
        vec_t e;
        e.rst = r; e.req = q; e.len = ln; e.rdy = rd;
        e.g = g; e.s = s; e.sx = sx; e.v = v; e.l = l; e.a = a;
        vt.push_back(e);
    endtask

    initial begin
        logic [13:0] act;
        logic [13:0] exp_v;
        int n;
        int nl;
        int last_at;

        // reset and idle
        for (int i = 0; i < 3; i++) add(1, 4'hF, 16'h0000, 1, 4'h0, 2'd0, 0, 0, 0, 4'h0);
        for (int i = 0; i < 2; i++) add(0, 4'h0, 16'h0000, 1, 4'h0, 2'd0, 0, 0, 0, 4'h0);
        // single 4-word burst from requester 2
        add(0, 4'h4, 16'h0300, 1, 4'h0, 2'd0, 0, 0, 0, 4'h0);
        for (int i = 0; i < 3; i++) add(0, 4'h0, 16'h0300, 1, 4'h4, 2'd2, 0, 1, 0, 4'h4);
        add(0, 4'h0, 16'h0300, 1, 4'h4, 2'd2, 0, 1, 1, 4'h4);
        add(0, 4'h0, 16'h0000, 1, 4'h0, 2'd0, 1, 0, 0, 4'h0);
        // re-reset so round robin starts at requester 0
        add(1, 4'h0, 16'h0000, 1, 4'h0, 2'd0, 1, 0, 0, 4'h0);
        add(0, 4'hF, 16'h0000, 1, 4'h0, 2'd0, 0, 0, 0, 4'h0);
        add(0, 4'hF, 16'h0000, 1, 4'h1, 2'd0, 0, 1, 1, 4'h1);
        add(0, 4'hF, 16'h0000, 1, 4'h2, 2'd1, 0, 1, 1, 4'h2);
        add(0, 4'hF, 16'h0000, 1, 4'h4, 2'd2, 0, 1, 1, 4'h4);
        add(0, 4'hF, 16'h0000, 1, 4'h8, 2'd3, 0, 1, 1, 4'h8);
        add(0, 4'hF, 16'h0000, 1, 4'h1, 2'd0, 0, 1, 1, 4'h1);
        add(0, 4'h0, 16'h0000, 1, 4'h2, 2'd1, 0, 1, 1, 4'h2);
        add(0, 4'h0, 16'h0000, 1, 4'h0, 2'd0, 1, 0, 0, 4'h0);
        // stall: 2-word burst from requester 1, ready low 5 cycles
        add(0, 4'h2, 16'h0010, 0, 4'h0, 2'd0, 1, 0, 0, 4'h0);
        for (int i = 0; i < 5; i++) add(0, 4'h0, 16'h0010, 0, 4'h2, 2'd1, 0, 1, 0, 4'h0);
        add(0, 4'h0, 16'h0010, 1, 4'h2, 2'd1, 0, 1, 0, 4'h2);
        add(0, 4'h0, 16'h0010, 1, 4'h2, 2'd1, 0, 1, 1, 4'h2);
        add(0, 4'h0, 16'h0000, 1, 4'h0, 2'd0, 1, 0, 0, 4'h0);
        // mid-burst req drop and len change on an 8-word burst
        add(0, 4'h8, 16'h7000, 1, 4'h0, 2'd0, 1, 0, 0, 4'h0);
        for (int i = 0; i < 2; i++) add(0, 4'h8, 16'h7000, 1, 4'h8, 2'd3, 0, 1, 0, 4'h8);
        for (int i = 0; i < 5; i++) add(0, 4'h0, 16'h1000, 1, 4'h8, 2'd3, 0, 1, 0, 4'h8);
        add(0, 4'h0, 16'h1000, 1, 4'h8, 2'd3, 0, 1, 1, 4'h8);
        add(0, 4'hF, 16'h0000, 1, 4'h0, 2'd0, 1, 0, 0, 4'h0);
        add(0, 4'h0, 16'h0000, 1, 4'h1, 2'd0, 0, 1, 1, 4'h1);
        // reset at the 3rd word of a 6-word burst
        add(0, 4'h4, 16'h0500, 1, 4'h0, 2'd0, 1, 0, 0, 4'h0);
        for (int i = 0; i < 2; i++) add(0, 4'h0, 16'h0500, 1, 4'h4, 2'd2, 0, 1, 0, 4'h4);
        add(1, 4'h0, 16'h0500, 0, 4'h4, 2'd2, 0, 1, 0, 4'h0);
        add(0, 4'hF, 16'h0000, 1, 4'h0, 2'd0, 0, 0, 0, 4'h0);
        add(0, 4'h0, 16'h0000, 1, 4'h1, 2'd0, 0, 1, 1, 4'h1);
        add(0, 4'h0, 16'h0000, 1, 4'h0, 2'd0, 1, 0, 0, 4'h0);

        rst = 1'b1; req = 4'h0; len = '0; out_ready = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vt.size(); i++) begin
            rst = vt[i].rst; req = vt[i].req; len = vt[i].len; out_ready = vt[i].rdy;
            #1;
            act   = {grant, (vt[i].sx ? 2'b00 : select), out_valid, out_last, word_ack, busy};
            exp_v = {vt[i].g, (vt[i].sx ? 2'b00 : vt[i].s), vt[i].v, vt[i].l, vt[i].a, vt[i].v};
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL vec%0d {grant,sel,valid,last,ack,busy} got %b want %b", i, act, exp_v);
            end
            @(posedge clk); #1;
        end

        // 10-word burst from requester 1 with ready held high
        rst = 1'b0; req = 4'h2; len = 16'h0090; out_ready = 1'b1;
        @(posedge clk); #1;
        req = 4'h0;
        n = 0; nl = 0; last_at = -1;
        for (int c = 0; c < 40 && out_valid; c++) begin
            if (out_last) begin nl++; last_at = n; end
            n++;
            @(posedge clk); #1;
        end
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL burst_len valid cycles got %0d want 10", n);
        end
        checks++;
        if (nl != 1 || last_at != 9) begin
            errors++;
            $display("FAIL burst_last count %0d at %0d want 1 at 9", nl, last_at);
        end
        checks++;
        if (out_valid !== 1'b0 || grant !== 4'h0) begin
            errors++;
            $display("FAIL burst_idle valid %b grant %b want 0 0000", out_valid, grant);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
